// File: rtl/analyzer_pkg.sv
// Shared analyzer definitions: default widths and the conditioner config record.
package analyzer_pkg;

    localparam int unsigned DIGITAL_IN_NUM_DEF = 8;
    localparam int unsigned DIV_WIDTH_DEF      = 16;
    localparam int unsigned FILT_WIDTH_DEF     = 4;
    localparam int unsigned CNT_WIDTH          = 32;

    // Active conditioner configuration, also used as the register-map field layout.
    typedef struct packed {
        logic [DIV_WIDTH_DEF-1:0]      div;
        logic [FILT_WIDTH_DEF-1:0]     filt;
        logic [DIGITAL_IN_NUM_DEF-1:0] invert;
    } cond_cfg_t;

endpackage

// File: rtl/analyzer_glitch_filter.sv
// One analyzer channel: 2-FF synchroniser, polarity, and persistence glitch filter.
module analyzer_glitch_filter
    import analyzer_pkg::*;
#(
    parameter int unsigned FILT_WIDTH = FILT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  din,
    input  logic                  invert,
    input  logic [FILT_WIDTH-1:0] filt,
    input  logic                  clr,
    output logic                  fq
);

    logic                  sync1;
    logic                  sync2;
    logic                  syn;
    logic [FILT_WIDTH-1:0] fc;

    assign syn = sync2 ^ invert;

    // Synchronise the pin, then accept a new level only after it persists filt+1 clocks.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            fc    <= '0;
            fq    <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (clr) begin
                fc <= '0;
            end else if (syn == fq) begin
                fc <= '0;
            end else if (fc == filt) begin
                fq <= syn;
                fc <= '0;
            end else begin
                fc <= fc + FILT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/analyzer_input_conditioner.sv
// Analyzer front end: per-channel sync/invert/filter, then sample-rate decimation.
module analyzer_input_conditioner
    import analyzer_pkg::*;
#(
    parameter int unsigned DIGITAL_IN_NUM = DIGITAL_IN_NUM_DEF,
    parameter int unsigned DIV_WIDTH      = DIV_WIDTH_DEF,
    parameter int unsigned FILT_WIDTH     = FILT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DIGITAL_IN_NUM-1:0] digital_in,
    input  logic [DIV_WIDTH-1:0]      cfg_div,
    input  logic [FILT_WIDTH-1:0]     cfg_filt,
    input  logic [DIGITAL_IN_NUM-1:0] cfg_invert,
    input  logic                      cfg_load,
    output logic [DIGITAL_IN_NUM-1:0] sample_out,
    output logic                      sample_valid,
    output logic                      edge_any,
    output logic [CNT_WIDTH-1:0]      sample_cnt
);

    cond_cfg_t                 cfg_act;
    logic [DIV_WIDTH-1:0]      dc;
    logic [DIGITAL_IN_NUM-1:0] fq_vec;
    logic                      first;

    // Per-channel conditioning; filter counters restart whenever a config is applied.
    for (genvar i = 0; i < int'(DIGITAL_IN_NUM); i++) begin : g_chan
        analyzer_glitch_filter #(
            .FILT_WIDTH (FILT_WIDTH)
        ) u_filt (
            .clk    (clk),
            .rstn   (rstn),
            .din    (digital_in[i]),
            .invert (cfg_act.invert[i]),
            .filt   (cfg_act.filt),
            .clr    (cfg_load),
            .fq     (fq_vec[i])
        );
    end

    // Config load, divider, sample capture, edge flag and saturating sample count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_act      <= '0;
            dc           <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            edge_any     <= 1'b0;
            sample_cnt   <= '0;
            first        <= 1'b1;
        end else if (cfg_load) begin
            cfg_act.div    <= DIV_WIDTH_DEF'(cfg_div);
            cfg_act.filt   <= FILT_WIDTH_DEF'(cfg_filt);
            cfg_act.invert <= DIGITAL_IN_NUM_DEF'(cfg_invert);
            dc             <= '0;
            sample_valid   <= 1'b0;
            edge_any       <= 1'b0;
            sample_cnt     <= '0;
            first          <= 1'b1;
        end else if (dc == DIV_WIDTH'(cfg_act.div)) begin
            dc           <= '0;
            sample_valid <= 1'b1;
            sample_out   <= fq_vec;
            edge_any     <= (fq_vec != sample_out) && !first;
            first        <= 1'b0;
            if (sample_cnt != '1) begin
                sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            end
        end else begin
            dc           <= dc + DIV_WIDTH'(1);
            sample_valid <= 1'b0;
            edge_any     <= 1'b0;
        end
    end

endmodule
